pc_seq_unit: RTL
================

Name: pc_seq_unit

Overview:
Parametrised program-counter unit for the CPU datapath. It replaces the single load-enable PC register. The PC supports absolute load, increment by STEP, PC-relative branch, and call/return through an internal return-address stack (RAS). It sits between the control unit (operation strobes) and the bus (D/Q). Q drives MAR/bus in fetch and branch steps.

Parameters:
WIDTH, 32, PC and data width in bits
INIT, 32'h0, PC value after reset (reset vector), WIDTH bits
STEP, 1, increment amount (word-addressed memory)
OFF_W, 19, width of signed branch offset (C-field of branch instruction)
RAS_DEPTH, 4, return-address stack entries, power of two, >=2

Ports:
clk  input  1  system clock, all state updates on rising edge
clr  input  1  synchronous active-high reset
enable  input  1  global qualifier; when 0, no state change except clr
load  input  1  absolute load: PC <= D
inc  input  1  PC <= PC + STEP
branch  input  1  PC <= PC + sign_extend(offset)
call  input  1  push PC+STEP onto RAS, PC <= D
ret  input  1  pop RAS into PC
D  input  WIDTH  load/call target from bus
offset  input  OFF_W  signed relative branch displacement
Q  output  WIDTH  current PC (registered)
ras_empty  output  1  RAS holds 0 entries
ras_full  output  1  RAS holds RAS_DEPTH entries
ras_err  output  1  sticky: overflow or underflow occurred since clr

Behaviour:
- Clock is clk; reset is clr, synchronous and active-high. There are no asynchronous paths and no initial blocks as a reset substitute.
- Reset values on the edge where clr=1: Q=INIT, RAS count=0, ras_empty=1, ras_full=0, ras_err=0. Stack storage contents are don't-care. clr overrides every other input, including enable=0.
- When enable=0 and clr=0, all state holds.
- Operation priority when several strobes are high with enable=1: load > call > ret > branch > inc. Only the highest-priority strobe takes effect; the rest are ignored with no side effects (e.g. load+call does not push).
- If no strobe is high, PC holds.
- Latency: the new PC is visible on Q one cycle after the strobe edge. ras_* flags update on the same edge.
- Arithmetic: all PC adds are modulo 2^WIDTH. PC+STEP from all-ones wraps to STEP-1.
- Branch: offset is sign-extended from OFF_W to WIDTH before the add. Negative offsets branch backwards.
- Call pushes (Q+STEP) mod 2^WIDTH, then PC <= D. When full, the RAS is circular: the oldest entry is overwritten, count stays RAS_DEPTH, and ras_err is set.
- Ret pops the top entry into PC. When empty: PC <= Q+STEP (treated as no-op advance), count stays 0, and ras_err is set.
- ras_err clears only on clr.
- Count range is 0..RAS_DEPTH. ras_full=(count==RAS_DEPTH) and ras_empty=(count==0), both registered-consistent with count.
- Pointer logic: top-of-stack index is log2(RAS_DEPTH) bits and wraps naturally. Push writes at tos+1; pop reads tos, then decrements.
- clr asserted while a call/ret strobe is high: reset wins, with no push or pop.

Decomposition:
- Shared package pc_pkg: PC operation encoding (enum OP_NONE, OP_INC, OP_BR, OP_RET, OP_CALL, OP_LOAD) and the priority-encode function.
- Constants: default INIT vector and STEP.
- One sub-module: ras_stack (circular LIFO with push/pop, count, full/empty, overflow/underflow pulses), parametrised by WIDTH and RAS_DEPTH.
- pc_seq_unit holds the PC register, adder/sign-extension, and priority select.

Test Plan:
- Reset and sequential increment: clr=1 for one edge with INIT=32'h0 -> Q=0, ras_empty=1. Then enable=1, inc=1 for 3 cycles -> Q=1,2,3. Then enable=0 with inc=1 -> Q holds at 3.
- Branch with negative offset: Q=32'h10, branch=1, offset=-4 (19'h7FFFC) -> Q=32'hC. Then offset=+5 -> Q=32'h11.
- Call/return with overflow: Q=32'h20, call with D=32'h100 -> Q=32'h100, RAS top=32'h21. Ret -> Q=32'h21, ras_empty=1. Then 5 calls with RAS_DEPTH=4 -> ras_full=1, ras_err=1. Then 4 rets -> the last 4 return addresses come back in LIFO order, and ras_empty=1.
- Underflow and priority: ret on empty RAS at Q=32'h40 -> Q=32'h41, ras_err=1. Then load=1, call=1, D=32'h200 together -> Q=32'h200 with the RAS count unchanged.
- Wrap and reset override: Q=32'hFFFFFFFF, inc -> Q=0. Then clr=1 with call=1, enable=0 -> Q=INIT, count=0, ras_err=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
// Holds the operation encoding, default constants and the strobe priority encoder.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_INC  = 3'd1,
        OP_BR   = 3'd2,
        OP_RET  = 3'd3,
        OP_CALL = 3'd4,
        OP_LOAD = 3'd5
    } pc_op_e;

    localparam logic [31:0] PC_INIT_DEF = 32'h0000_0000;
    localparam int          PC_STEP_DEF = 1;

    // Strobes may overlap; the highest-priority one wins and the rest are dropped.
    function automatic pc_op_e pc_op_sel(
        input logic i_load,
        input logic i_call,
        input logic i_ret,
        input logic i_branch,
        input logic i_inc
    );
        pc_op_e op;
        op = OP_NONE;
        if (i_load)
            op = OP_LOAD;
        else if (i_call)
            op = OP_CALL;
        else if (i_ret)
            op = OP_RET;
        else if (i_branch)
            op = OP_BR;
        else if (i_inc)
            op = OP_INC;
        return op;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with saturating count.
// A push on a full stack overwrites the oldest entry; a pop on an empty stack is refused.
module ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_tos;
    logic [CW-1:0]    r_count;

    logic [PW-1:0]    w_wr_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_wr_ptr  = r_tos + PW'(1);
    assign w_do_push = push;
    assign w_do_pop  = pop & ~push & ~empty;

    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);
    assign ovf      = push & full;
    assign unf      = pop & ~push & empty;
    assign top_data = r_mem[r_tos];

    always_ff @(posedge clk) begin
        if (clr) begin
            r_tos   <= '0;
            r_count <= '0;
        end else if (w_do_push) begin
            r_tos <= w_wr_ptr;
            if (!full)
                r_count <= r_count + CW'(1);
        end else if (w_do_pop) begin
            r_tos   <= r_tos - PW'(1);
            r_count <= r_count - CW'(1);
        end
    end

    // Storage needs no reset; only the pointer and count define validity.
    always_ff @(posedge clk) begin
        if (!clr && w_do_push)
            r_mem[w_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Program counter with load, increment, relative branch and call/return.
// Return addresses live in an internal circular stack with a sticky error flag.
module pc_seq_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] INIT      = WIDTH'(PC_INIT_DEF),
    parameter int               STEP      = PC_STEP_DEF,
    parameter int               OFF_W     = 19,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             load,
    input  logic             inc,
    input  logic             branch,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] D,
    input  logic [OFF_W-1:0] offset,
    output logic [WIDTH-1:0] Q,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam logic [WIDTH-1:0] LP_STEP = WIDTH'(STEP);

    logic [WIDTH-1:0] r_pc;
    logic             r_err;

    pc_op_e           w_op;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_off_ext;
    logic [WIDTH-1:0] w_pc_br;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_full;
    logic             w_empty;
    logic             w_ovf;
    logic             w_unf;

    assign w_op = enable ? pc_op_sel(load, call, ret, branch, inc) : OP_NONE;

    // clr must suppress stack traffic even when a call/ret strobe is present.
    assign w_push = ~clr & (w_op == OP_CALL);
    assign w_pop  = ~clr & (w_op == OP_RET);

    assign w_pc_inc  = r_pc + LP_STEP;
    assign w_off_ext = {{(WIDTH - OFF_W){offset[OFF_W-1]}}, offset};
    assign w_pc_br   = r_pc + w_off_ext;

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .clr       (clr),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top_data  (w_ras_top),
        .full      (w_full),
        .empty     (w_empty),
        .ovf       (w_ovf),
        .unf       (w_unf)
    );

    always_comb begin
        w_pc_nxt = r_pc;
        unique case (w_op)
            OP_LOAD: w_pc_nxt = D;
            OP_CALL: w_pc_nxt = D;
            OP_RET:  w_pc_nxt = w_empty ? w_pc_inc : w_ras_top;
            OP_BR:   w_pc_nxt = w_pc_br;
            OP_INC:  w_pc_nxt = w_pc_inc;
            OP_NONE: w_pc_nxt = r_pc;
            default: w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_pc  <= INIT;
            r_err <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_ovf || w_unf)
                r_err <= 1'b1;
        end
    end

    assign Q         = r_pc;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_err   = r_err;

endmodule
